bsa_layer_ctrl: RTL and testbench
=================================

Name: bsa_layer_ctrl

Overview:
- Per-layer sequencer for the bias/scale/activation (BSA) post-processing stage that follows the MAC array.
- Holds a per-output-channel bias/scale register file and the layer configuration (shift, last-layer flag).
- Forwards MAC results to the BSA stage with the matching channel's bias/scale attached, in the same registered cycle.
- Counts BSA outputs to flag layer completion, and flags stream protocol errors.

Parameters:
- PARAM_BITS, 16, bias and scale width.
- MAC_OUT_BITS, 24, MAC accumulator width.
- MAX_CH, 64, depth of the bias/scale register file (output channels per layer).
- CH_W, 6, channel index width; log2(MAX_CH).
- PIX_W, 12, pixel count width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse; latches cfg_* and starts a layer.
- cfg_num_ch  in  CH_W+1  output channels per pixel, 0..MAX_CH.
- cfg_num_pix  in  PIX_W  pixels in the layer.
- cfg_scale_shift  in  6  right-shift amount for the layer.
- cfg_is_last  in  1  last-layer flag (bypasses activation).
- param_we  in  1  register-file write enable.
- param_waddr  in  CH_W  channel index to write.
- param_wbias  in  PARAM_BITS  bias value to write.
- param_wscale  in  PARAM_BITS  scale value to write.
- mac_vld  in  1  MAC result valid; one channel per beat, channel order 0..num_ch-1 within each pixel.
- mac_data  in  MAC_OUT_BITS  MAC result.
- bsa_accum_vld_out  in  1  valid output from the BSA stage.
- bsa_accum_in  out  MAC_OUT_BITS  accumulator data to the BSA stage.
- bsa_accum_vld_in  out  1  valid to the BSA stage.
- bsa_bias  out  PARAM_BITS  bias to the BSA stage.
- bsa_scale  out  PARAM_BITS  scale to the BSA stage.
- bsa_scale_shift  out  6  shift to the BSA stage.
- bsa_is_last_layer  out  1  last-layer flag to the BSA stage.
- busy  out  1  high in LOAD, RUN and DRAIN.
- layer_done  out  1  one-cycle completion pulse.
- err_overrun  out  1  sticky protocol-error flag.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0, err_overrun 0.
- The register file is not reset; its contents are undefined until written.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - param_we writes bias/scale at param_waddr; param_we is ignored in every other state.
  - cfg_start latches cfg_*, clears ch_cnt, pix_cnt, out_cnt and err_overrun, then moves to LOAD.
  - cfg_start with cfg_num_ch==0, cfg_num_ch>MAX_CH, or cfg_num_pix==0 goes straight to DONE, and err_overrun is set if cfg_num_ch>MAX_CH.
- LOAD: lasts one cycle and drives the latched shift and last flag onto bsa_scale_shift and bsa_is_last_layer. Those outputs hold until the next cfg_start. Next state is RUN.
- RUN, for each cycle with mac_vld=1, the next cycle drives:
  - bsa_accum_in = mac_data;
  - bsa_bias = bias[ch_cnt];
  - bsa_scale = scale[ch_cnt];
  - bsa_accum_vld_in = 1.
  - Forwarding latency is exactly 1 cycle, with bias/scale aligned to the same beat.
- Counter advance in RUN:
  - ch_cnt increments on each beat.
  - When ch_cnt == num_ch-1 it wraps to 0 and pix_cnt increments.
  - When ch_cnt == num_ch-1 and pix_cnt == num_pix-1, the state moves to DRAIN after forwarding that beat.
- bsa_accum_vld_in is 0 in every cycle not forwarding a beat. bsa_accum_in, bsa_bias and bsa_scale hold their last value.
- mac_vld in IDLE, LOAD, DRAIN or DONE: the beat is dropped, err_overrun is set, and the state is unchanged.
- out_cnt (width CH_W+1+PIX_W) increments on every bsa_accum_vld_out in LOAD, RUN and DRAIN.
- DRAIN: when out_cnt reaches num_ch*num_pix, including on the incrementing cycle, the state moves to DONE. There is no timeout.
- DONE: layer_done=1 for exactly one cycle, then IDLE.
- busy is 0 in IDLE and DONE.
- cfg_start outside IDLE is ignored; no error is raised.
- Asynchronous reset mid-layer: returns to IDLE immediately and outputs drop to reset values next edge-free instant. Register-file contents are retained.
- Simultaneous param_we and cfg_start in IDLE: the write commits, and the layer uses the new value.

Decomposition:
- Shared package bsa_pkg holds the FSM state enum, the default widths (PARAM_BITS, MAC_OUT_BITS, MAX_CH) and the BSA pipeline depth constant (4).
- One sub-module: bsa_param_rf. It is a MAX_CH x (2*PARAM_BITS) register file with 1 write port and 1 combinational read port, and no reset.

Test Plan:
- Basic layer:
  - Stimulus: write bias[c]=10*c and scale[c]=c+1 for c=0..3; start with num_ch=4, num_pix=2, shift=8; send 8 consecutive mac_vld beats with data 100..107.
  - Required: 8 forwarded beats, each 1 cycle after its input, with beat k carrying bias=10*(k%4) and scale=(k%4)+1.
  - Required: bsa_scale_shift=8; after a 4-cycle delayed vld_out model returns 8 outputs, exactly one layer_done pulse and busy=0.
- Gapped input: same layer with mac_vld toggling 1,0,1,0 -> channel index advances only on valid beats; no bias/scale misalignment.
- Overrun: a mac_vld beat in IDLE, and a ninth beat in DRAIN -> err_overrun=1, no bsa_accum_vld_in on either beat, and layer_done still fires after 8 outputs.
- Degenerate configurations:
  - num_pix=0 -> layer_done 1 cycle after DONE entry, no forwarded beats, err_overrun=0.
  - num_ch=MAX_CH+1 -> layer_done with err_overrun=1.
- Reset mid-RUN: assert rstn=0 after 3 beats -> all outputs 0 and IDLE. A restarted layer with no param rewrite uses the previously written bias/scale and completes normally.
- Ignored requests: param_we during RUN leaves the register file unchanged; cfg_start during RUN leaves the latched num_ch and shift unchanged.

Source files
------------

// File: rtl/bsa_pkg.sv
// Shared types and default widths for the BSA layer controller.
package bsa_pkg;

  localparam int unsigned BSA_PARAM_BITS   = 16;
  localparam int unsigned BSA_MAC_OUT_BITS = 24;
  localparam int unsigned BSA_MAX_CH       = 64;
  localparam int unsigned BSA_CH_W         = 6;
  localparam int unsigned BSA_PIX_W        = 12;
  localparam int unsigned BSA_SHIFT_W      = 6;

  // Latency of the downstream bias/scale/activation pipeline.
  localparam int unsigned BSA_PIPE_DEPTH   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bsa_state_e;

endpackage

// File: rtl/bsa_param_rf.sv
// Per-output-channel bias/scale register file: one write port, one
// combinational read port, no reset (contents undefined until written).
module bsa_param_rf
  import bsa_pkg::*;
#(
  parameter int unsigned PARAM_BITS = BSA_PARAM_BITS,
  parameter int unsigned MAX_CH     = BSA_MAX_CH,
  parameter int unsigned CH_W       = BSA_CH_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [CH_W-1:0]       waddr,
  input  logic [PARAM_BITS-1:0] wbias,
  input  logic [PARAM_BITS-1:0] wscale,
  input  logic [CH_W-1:0]       raddr,
  output logic [PARAM_BITS-1:0] rbias_c,
  output logic [PARAM_BITS-1:0] rscale_c
);

  localparam int unsigned ENTRY_W = 2 * PARAM_BITS;

  logic [ENTRY_W-1:0] mem [MAX_CH];

  // Write port; entries are {bias, scale}.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= {wbias, wscale};
    end
  end

  assign {rbias_c, rscale_c} = mem[raddr];

endmodule

// File: rtl/bsa_layer_ctrl.sv
// Per-layer sequencer for the BSA stage: latches layer config, forwards MAC
// beats with their channel's bias/scale, counts BSA outputs for completion.
module bsa_layer_ctrl
  import bsa_pkg::*;
#(
  parameter int unsigned PARAM_BITS   = BSA_PARAM_BITS,
  parameter int unsigned MAC_OUT_BITS = BSA_MAC_OUT_BITS,
  parameter int unsigned MAX_CH       = BSA_MAX_CH,
  parameter int unsigned CH_W         = BSA_CH_W,
  parameter int unsigned PIX_W        = BSA_PIX_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cfg_start,
  input  logic [CH_W:0]           cfg_num_ch,
  input  logic [PIX_W-1:0]        cfg_num_pix,
  input  logic [BSA_SHIFT_W-1:0]  cfg_scale_shift,
  input  logic                    cfg_is_last,
  input  logic                    param_we,
  input  logic [CH_W-1:0]         param_waddr,
  input  logic [PARAM_BITS-1:0]   param_wbias,
  input  logic [PARAM_BITS-1:0]   param_wscale,
  input  logic                    mac_vld,
  input  logic [MAC_OUT_BITS-1:0] mac_data,
  input  logic                    bsa_accum_vld_out,
  output logic [MAC_OUT_BITS-1:0] bsa_accum_in,
  output logic                    bsa_accum_vld_in,
  output logic [PARAM_BITS-1:0]   bsa_bias,
  output logic [PARAM_BITS-1:0]   bsa_scale,
  output logic [BSA_SHIFT_W-1:0]  bsa_scale_shift,
  output logic                    bsa_is_last_layer,
  output logic                    busy,
  output logic                    layer_done,
  output logic                    err_overrun
);

  localparam int unsigned NCH_W = CH_W + 1;
  localparam int unsigned CNT_W = CH_W + 1 + PIX_W;

  bsa_state_e              state_q, state_d;
  logic [CH_W-1:0]         ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0]        pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]        total_q, total_d;
  logic [NCH_W-1:0]        num_ch_q, num_ch_d;
  logic [PIX_W-1:0]        num_pix_q, num_pix_d;
  logic [BSA_SHIFT_W-1:0]  shift_q, shift_d;
  logic                    last_q, last_d;

  logic [MAC_OUT_BITS-1:0] accum_d;
  logic                    vld_d;
  logic [PARAM_BITS-1:0]   bias_d, scale_d;
  logic [BSA_SHIFT_W-1:0]  shift_out_d;
  logic                    is_last_out_d;
  logic                    busy_d, done_d, err_d;

  logic                    rf_we_c;
  logic [PARAM_BITS-1:0]   rd_bias_c, rd_scale_c;
  logic                    last_ch_c, last_pix_c, cfg_ovf_c, cfg_bad_c;

  // Writes are only honoured while no layer is in flight.
  assign rf_we_c    = param_we && (state_q == ST_IDLE);
  assign last_ch_c  = ({1'b0, ch_cnt_q} == (num_ch_q - NCH_W'(1)));
  assign last_pix_c = (pix_cnt_q == (num_pix_q - PIX_W'(1)));
  assign cfg_ovf_c  = (cfg_num_ch > NCH_W'(MAX_CH));
  assign cfg_bad_c  = cfg_ovf_c || (cfg_num_ch == '0) || (cfg_num_pix == '0);

  bsa_param_rf #(
    .PARAM_BITS (PARAM_BITS),
    .MAX_CH     (MAX_CH),
    .CH_W       (CH_W)
  ) u_param_rf (
    .clk      (clk),
    .we       (rf_we_c),
    .waddr    (param_waddr),
    .wbias    (param_wbias),
    .wscale   (param_wscale),
    .raddr    (ch_cnt_q),
    .rbias_c  (rd_bias_c),
    .rscale_c (rd_scale_c)
  );

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d       = state_q;
    ch_cnt_d      = ch_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    out_cnt_d     = out_cnt_q;
    total_d       = total_q;
    num_ch_d      = num_ch_q;
    num_pix_d     = num_pix_q;
    shift_d       = shift_q;
    last_d        = last_q;
    accum_d       = bsa_accum_in;
    vld_d         = 1'b0;
    bias_d        = bsa_bias;
    scale_d       = bsa_scale;
    shift_out_d   = bsa_scale_shift;
    is_last_out_d = bsa_is_last_layer;
    err_d         = err_overrun;

    if (bsa_accum_vld_out &&
        ((state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DRAIN))) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          num_ch_d  = cfg_num_ch;
          num_pix_d = cfg_num_pix;
          shift_d   = cfg_scale_shift;
          last_d    = cfg_is_last;
          total_d   = CNT_W'(cfg_num_ch) * CNT_W'(cfg_num_pix);
          ch_cnt_d  = '0;
          pix_cnt_d = '0;
          out_cnt_d = '0;
          err_d     = cfg_ovf_c;
          state_d   = cfg_bad_c ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_out_d   = shift_q;
        is_last_out_d = last_q;
        state_d       = ST_RUN;
      end
      ST_RUN: begin
        if (mac_vld) begin
          vld_d   = 1'b1;
          accum_d = mac_data;
          bias_d  = rd_bias_c;
          scale_d = rd_scale_c;
          if (last_ch_c) begin
            ch_cnt_d  = '0;
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
            if (last_pix_c) begin
              state_d = ST_DRAIN;
            end
          end else begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (out_cnt_d >= total_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A beat arriving outside RUN is dropped and flagged.
    if (mac_vld && (state_q != ST_RUN)) begin
      err_d = 1'b1;
    end

    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_q == ST_DONE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q           <= ST_IDLE;
      ch_cnt_q          <= '0;
      pix_cnt_q         <= '0;
      out_cnt_q         <= '0;
      total_q           <= '0;
      num_ch_q          <= '0;
      num_pix_q         <= '0;
      shift_q           <= '0;
      last_q            <= 1'b0;
      bsa_accum_in      <= '0;
      bsa_accum_vld_in  <= 1'b0;
      bsa_bias          <= '0;
      bsa_scale         <= '0;
      bsa_scale_shift   <= '0;
      bsa_is_last_layer <= 1'b0;
      busy              <= 1'b0;
      layer_done        <= 1'b0;
      err_overrun       <= 1'b0;
    end else begin
      state_q           <= state_d;
      ch_cnt_q          <= ch_cnt_d;
      pix_cnt_q         <= pix_cnt_d;
      out_cnt_q         <= out_cnt_d;
      total_q           <= total_d;
      num_ch_q          <= num_ch_d;
      num_pix_q         <= num_pix_d;
      shift_q           <= shift_d;
      last_q            <= last_d;
      bsa_accum_in      <= accum_d;
      bsa_accum_vld_in  <= vld_d;
      bsa_bias          <= bias_d;
      bsa_scale         <= scale_d;
      bsa_scale_shift   <= shift_out_d;
      bsa_is_last_layer <= is_last_out_d;
      busy              <= busy_d;
      layer_done        <= done_d;
      err_overrun       <= err_d;
    end
  end

endmodule

// File: tb/tb_bsa_layer_ctrl.sv
// Self-checking bench for bsa_layer_ctrl: scoreboard of forwarded beats
// against a bench-side bias/scale model, plus a delayed BSA vld_out model.
module tb_bsa_layer_ctrl;
  import bsa_pkg::*;

  localparam int unsigned PB   = 16;
  localparam int unsigned MB   = 24;
  localparam int unsigned MAXC = 64;
  localparam int unsigned CW   = 6;
  localparam int unsigned PW   = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          cfg_start = 1'b0;
  logic [CW:0]   cfg_num_ch = '0;
  logic [PW-1:0] cfg_num_pix = '0;
  logic [5:0]    cfg_scale_shift = '0;
  logic          cfg_is_last = 1'b0;
  logic          param_we = 1'b0;
  logic [CW-1:0] param_waddr = '0;
  logic [PB-1:0] param_wbias = '0;
  logic [PB-1:0] param_wscale = '0;
  logic          mac_vld = 1'b0;
  logic [MB-1:0] mac_data = '0;
  logic          bsa_accum_vld_out;
  logic [MB-1:0] bsa_accum_in;
  logic          bsa_accum_vld_in;
  logic [PB-1:0] bsa_bias;
  logic [PB-1:0] bsa_scale;
  logic [5:0]    bsa_scale_shift;
  logic          bsa_is_last_layer;
  logic          busy;
  logic          layer_done;
  logic          err_overrun;

  typedef struct packed {
    logic [MB-1:0] data;
    logic [PB-1:0] bias;
    logic [PB-1:0] scale;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned exp_cyc_q[$];
  beat_t       mon_exp, mon_got;
  int unsigned mon_cyc;

  int          tests_run = 0;
  int          tests_failed = 0;
  int unsigned cyc = 0;
  int          fwd_beats = 0;
  int unsigned start_cyc = 0;

  logic [PB-1:0] m_bias  [MAXC];
  logic [PB-1:0] m_scale [MAXC];
  logic [BSA_PIPE_DEPTH-1:0] pipe;

  bsa_layer_ctrl dut (
    .clk               (clk),
    .rstn              (rstn),
    .cfg_start         (cfg_start),
    .cfg_num_ch        (cfg_num_ch),
    .cfg_num_pix       (cfg_num_pix),
    .cfg_scale_shift   (cfg_scale_shift),
    .cfg_is_last       (cfg_is_last),
    .param_we          (param_we),
    .param_waddr       (param_waddr),
    .param_wbias       (param_wbias),
    .param_wscale      (param_wscale),
    .mac_vld           (mac_vld),
    .mac_data          (mac_data),
    .bsa_accum_vld_out (bsa_accum_vld_out),
    .bsa_accum_in      (bsa_accum_in),
    .bsa_accum_vld_in  (bsa_accum_vld_in),
    .bsa_bias          (bsa_bias),
    .bsa_scale         (bsa_scale),
    .bsa_scale_shift   (bsa_scale_shift),
    .bsa_is_last_layer (bsa_is_last_layer),
    .busy              (busy),
    .layer_done        (layer_done),
    .err_overrun       (err_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BSA stage stand-in: vld_out follows vld_in by the pipeline depth.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) pipe <= '0;
    else       pipe <= {pipe[BSA_PIPE_DEPTH-2:0], bsa_accum_vld_in};
  end
  assign bsa_accum_vld_out = pipe[BSA_PIPE_DEPTH-1];

  // Scoreboard monitor: every forwarded beat must match the oldest expectation.
  always @(negedge clk) begin
    if (bsa_accum_vld_in) begin
      fwd_beats++;
      tests_run++;
      mon_got = {bsa_accum_in, bsa_bias, bsa_scale};
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_beat: got data=%0d bias=%0d scale=%0d at cyc %0d, required no beat",
                 bsa_accum_in, bsa_bias, bsa_scale, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        if (mon_got !== mon_exp || cyc != mon_cyc) begin
          tests_failed++;
          $display("FAIL fwd_beat: got data=%0d bias=%0d scale=%0d cyc=%0d, required data=%0d bias=%0d scale=%0d cyc=%0d",
                   mon_got.data, mon_got.bias, mon_got.scale, cyc,
                   mon_exp.data, mon_exp.bias, mon_exp.scale, mon_cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_param(input int ch, input int b, input int s);
    param_we     = 1'b1;
    param_waddr  = CW'(ch);
    param_wbias  = PB'(b);
    param_wscale = PB'(s);
    tick();
    param_we     = 1'b0;
    m_bias[ch]   = PB'(b);
    m_scale[ch]  = PB'(s);
  endtask

  task automatic start_layer(input int nch, input int npix, input int sh, input logic lst);
    cfg_num_ch      = (CW+1)'(nch);
    cfg_num_pix     = PW'(npix);
    cfg_scale_shift = 6'(sh);
    cfg_is_last     = lst;
    cfg_start       = 1'b1;
    start_cyc       = cyc;
    tick();
    cfg_start       = 1'b0;
    tick();
  endtask

  task automatic send_beats(input int k0, input int n, input int nch, input int gap, input int base);
    for (int k = k0; k < k0 + n; k++) begin
      beat_t e;
      e.data  = MB'(base + k);
      e.bias  = m_bias[k % nch];
      e.scale = m_scale[k % nch];
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + 1);
      mac_vld  = 1'b1;
      mac_data = MB'(base + k);
      tick();
      mac_vld  = 1'b0;
      if (gap != 0) tick();
    end
  endtask

  task automatic wait_done(input int budget, output int pulses, output int unsigned first_cyc);
    pulses    = 0;
    first_cyc = 0;
    repeat (budget) begin
      @(negedge clk);
      if (layer_done) begin
        if (pulses == 0) first_cyc = cyc;
        pulses++;
      end
    end
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #20;
    tests_run++;
    if ({busy, layer_done, err_overrun, bsa_accum_vld_in} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy/done/err/vld=%b, required 0000",
               {busy, layer_done, err_overrun, bsa_accum_vld_in});
    end
    tests_run++;
    if ({bsa_accum_in, bsa_bias, bsa_scale} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got accum=%0h bias=%0h scale=%0h, required 0",
               bsa_accum_in, bsa_bias, bsa_scale);
    end
    tests_run++;
    if ({bsa_scale_shift, bsa_is_last_layer} !== '0) begin
      tests_failed++;
      $display("FAIL reset_cfg: got shift=%0d last=%b, required 0", bsa_scale_shift, bsa_is_last_layer);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int p;
    int unsigned fc;
    int b0;
    for (int c = 0; c < 4; c++) write_param(c, 10 * c, c + 1);
    b0 = fwd_beats;
    start_layer(4, 2, 8, 1'b0);
    tests_run++;
    if (bsa_scale_shift !== 6'd8 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_shift_busy: got shift=%0d busy=%b, required shift=8 busy=1", bsa_scale_shift, busy);
    end
    send_beats(0, 8, 4, 0, 100);
    wait_done(40, p, fc);
    tests_run++;
    if (p != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done: got pulses=%0d busy=%b, required pulses=1 busy=0", p, busy);
    end
    tests_run++;
    if (fwd_beats - b0 != 8 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_count: got beats=%0d pending=%0d, required beats=8 pending=0", fwd_beats - b0, exp_q.size());
    end
    tests_run++;
    if (err_overrun !== 1'b0 || bsa_is_last_layer !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_flags: got err=%b last=%b, required err=0 last=0", err_overrun, bsa_is_last_layer);
    end
  endtask

  task automatic test_gapped();
    int p;
    int unsigned fc;
    int b0;
    b0 = fwd_beats;
    start_layer(4, 2, 3, 1'b1);
    tests_run++;
    if (bsa_is_last_layer !== 1'b1 || bsa_scale_shift !== 6'd3) begin
      tests_failed++;
      $display("FAIL gapped_cfg: got last=%b shift=%0d, required last=1 shift=3", bsa_is_last_layer, bsa_scale_shift);
    end
    send_beats(0, 8, 4, 1, 200);
    wait_done(40, p, fc);
    tests_run++;
    if (p != 1 || fwd_beats - b0 != 8 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL gapped_done: got pulses=%0d beats=%0d pending=%0d, required 1/8/0", p, fwd_beats - b0, exp_q.size());
    end
  endtask

  task automatic test_overrun();
    int p;
    int unsigned fc;
    int b0;
    b0 = fwd_beats;
    mac_vld  = 1'b1;
    mac_data = MB'(999);
    tick();
    mac_vld  = 1'b0;
    tests_run++;
    if (err_overrun !== 1'b1 || bsa_accum_vld_in !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_overrun: got err=%b vld=%b, required err=1 vld=0", err_overrun, bsa_accum_vld_in);
    end
    start_layer(4, 2, 5, 1'b0);
    tests_run++;
    if (err_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_clears_err: got err=%b, required 0", err_overrun);
    end
    send_beats(0, 8, 4, 0, 300);
    mac_vld  = 1'b1;
    mac_data = MB'(888);
    tick();
    mac_vld  = 1'b0;
    tests_run++;
    if (err_overrun !== 1'b1 || bsa_accum_vld_in !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_overrun: got err=%b vld=%b, required err=1 vld=0", err_overrun, bsa_accum_vld_in);
    end
    wait_done(40, p, fc);
    tests_run++;
    if (p != 1 || fwd_beats - b0 != 8 || err_overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_done: got pulses=%0d beats=%0d err=%b, required 1/8/1", p, fwd_beats - b0, err_overrun);
    end
  endtask

  task automatic test_degenerate();
    int p;
    int unsigned fc;
    int unsigned c0;
    int b0;
    b0 = fwd_beats;
    start_layer(4, 0, 2, 1'b0);
    c0 = start_cyc;
    wait_done(10, p, fc);
    tests_run++;
    if (p != 1 || fc != c0 + 2 || err_overrun !== 1'b0 || fwd_beats != b0) begin
      tests_failed++;
      $display("FAIL zero_pix: got pulses=%0d done_cyc=%0d err=%b beats=%0d, required 1/%0d/0/0",
               p, fc, err_overrun, fwd_beats - b0, c0 + 2);
    end
    start_layer(MAXC + 1, 2, 2, 1'b0);
    wait_done(10, p, fc);
    tests_run++;
    if (p != 1 || err_overrun !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL too_many_ch: got pulses=%0d err=%b busy=%b, required 1/1/0", p, err_overrun, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int p;
    int unsigned fc;
    int b0;
    start_layer(4, 2, 8, 1'b1);
    send_beats(0, 3, 4, 0, 400);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    tests_run++;
    if ({busy, layer_done, err_overrun, bsa_accum_vld_in, bsa_is_last_layer} !== 5'b0 ||
        {bsa_accum_in, bsa_bias, bsa_scale, bsa_scale_shift} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset: got busy=%b vld=%b accum=%0d bias=%0d scale=%0d shift=%0d, required all 0",
               busy, bsa_accum_vld_in, bsa_accum_in, bsa_bias, bsa_scale, bsa_scale_shift);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL mid_reset_pending: got %0d pending, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    b0 = fwd_beats;
    start_layer(4, 1, 8, 1'b0);
    send_beats(0, 4, 4, 0, 500);
    wait_done(40, p, fc);
    tests_run++;
    if (p != 1 || fwd_beats - b0 != 4 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL restart: got pulses=%0d beats=%0d pending=%0d, required 1/4/0", p, fwd_beats - b0, exp_q.size());
    end
  endtask

  task automatic test_ignored();
    int p;
    int unsigned fc;
    int b0;
    b0 = fwd_beats;
    start_layer(4, 2, 8, 1'b0);
    send_beats(0, 2, 4, 0, 600);
    param_we        = 1'b1;
    param_waddr     = CW'(1);
    param_wbias     = PB'(999);
    param_wscale    = PB'(77);
    cfg_start       = 1'b1;
    cfg_num_ch      = (CW+1)'(2);
    cfg_scale_shift = 6'd3;
    tick();
    param_we  = 1'b0;
    cfg_start = 1'b0;
    send_beats(2, 6, 4, 0, 600);
    wait_done(40, p, fc);
    tests_run++;
    if (p != 1 || fwd_beats - b0 != 8 || exp_q.size() != 0 || bsa_scale_shift !== 6'd8) begin
      tests_failed++;
      $display("FAIL ignored_run: got pulses=%0d beats=%0d pending=%0d shift=%0d, required 1/8/0/8",
               p, fwd_beats - b0, exp_q.size(), bsa_scale_shift);
    end
    b0 = fwd_beats;
    start_layer(4, 1, 8, 1'b0);
    send_beats(0, 4, 4, 0, 650);
    wait_done(40, p, fc);
    tests_run++;
    if (p != 1 || fwd_beats - b0 != 4 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL ignored_readback: got pulses=%0d beats=%0d pending=%0d, required 1/4/0", p, fwd_beats - b0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int p;
    int unsigned fc;
    int b0;
    b0 = fwd_beats;
    param_we        = 1'b1;
    param_waddr     = '0;
    param_wbias     = PB'(77);
    param_wscale    = PB'(5);
    cfg_num_ch      = (CW+1)'(1);
    cfg_num_pix     = PW'(2);
    cfg_scale_shift = 6'd1;
    cfg_is_last     = 1'b0;
    cfg_start       = 1'b1;
    tick();
    param_we   = 1'b0;
    cfg_start  = 1'b0;
    m_bias[0]  = PB'(77);
    m_scale[0] = PB'(5);
    tick();
    send_beats(0, 2, 1, 0, 700);
    wait_done(40, p, fc);
    tests_run++;
    if (p != 1 || fwd_beats - b0 != 2 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL write_with_start: got pulses=%0d beats=%0d pending=%0d, required 1/2/0", p, fwd_beats - b0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overrun();
    test_degenerate();
    test_reset_mid_run();
    test_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
